// File: rtl/ps2_key_pkg.sv
// ps2_key_pkg
// Shared types and constants for the PS/2 scan-code decoder slice.
//   key_state_t  : decoder FSM states
//   key_event_t  : one decoded key event as stored in the event FIFO
//   byte/modifier constants and the ignored-byte helper
package ps2_key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GOT_E0,
        GOT_F0,
        GOT_E0F0,
        SKIP_E1
    } key_state_t;

    // Prefix bytes of the scan-code set 2 stream
    localparam logic [7:0] PFX_E0     = 8'hE0;
    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] PFX_E1     = 8'hE1;

    // Modifier scan codes (12 also serves as the E0-prefixed fake shift)
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;
    localparam logic [7:0] CODE_CTRL   = 8'h14;
    localparam logic [7:0] CODE_ALT    = 8'h11;
    localparam logic [7:0] CODE_CAPS   = 8'h58;

    // Pause is reported as an extended make of this code
    localparam logic [7:0] CODE_PAUSE  = 8'h77;

    // Bytes that follow E1 in the Pause sequence
    localparam logic [2:0] PAUSE_TAIL_LEN = 3'd7;

    // Bit positions inside the 4-bit modifier snapshot
    localparam int MOD_SHIFT = 0;
    localparam int MOD_CTRL  = 1;
    localparam int MOD_ALT   = 2;
    localparam int MOD_CAPS  = 3;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [3:0] mods;
    } key_event_t;

    // Keyboard status/response bytes that never start a key sequence
    localparam int N_IGNORED = 7;
    localparam logic [7:0] IGNORED_BYTES [N_IGNORED] =
        '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

    function automatic logic is_ignored(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_IGNORED; i++) begin
            if (b == IGNORED_BYTES[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_fifo.sv
// ps2_key_fifo
// Synchronous show-ahead FIFO for decoded key events.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   wr_en      : push request; accepted when not full, or when full with rd_en
//   wr_data    : pushed word
//   rd_en      : pop request; ignored while empty
//   rd_data    : head word, forced to 0 while empty
//   empty/full : occupancy flags
//   count      : number of stored words
module ps2_key_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = 14
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt;
    logic              do_wr;
    logic              do_rd;

    assign empty = (cnt == '0);
    assign full  = (cnt == (AW+1)'(FIFO_DEPTH));

    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign do_wr = wr_en & (~full | rd_en);
    assign do_rd = rd_en & ~empty;

    assign rd_data = empty ? '0 : mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// Turns the ps2_rx byte stream into key events (make/break, extended flag,
// modifier snapshot) and queues them in a show-ahead event FIFO.
//   clk, rst_n        : clock, asynchronous active-low reset
//   rx_valid, rx_data : one-cycle byte strobe from ps2_rx
//   ev_valid/ev_ready : event handshake to the consumer
//   ev_code/ev_ext/ev_break/ev_mods : head event fields (0 when empty)
//   fifo_count        : stored event count
//   overflow, ov_clr  : sticky drop flag and its clear (drop wins)
module ps2_key_decoder
    import ps2_key_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int TYPEMATIC_EN = 0,
    parameter int TIMEOUT_CYC  = 100000,
    parameter int PAUSE_EN     = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_data,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [7:0]                    ev_code,
    output logic                          ev_ext,
    output logic                          ev_break,
    output logic [3:0]                    ev_mods,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          ov_clr
);

    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    key_state_t      state;
    key_state_t      state_nxt;
    logic [2:0]      pause_cnt;
    logic [2:0]      pause_nxt;
    logic [TO_W-1:0] to_cnt;
    logic            timeout_hit;

    logic            form_vld;
    logic [7:0]      form_code;
    logic            form_ext;
    logic            form_brk;
    logic            form_pause;
    logic            is_repeat;

    logic            shift_l, shift_r, ctrl_q, alt_q, caps_q;
    logic            shift_l_nxt, shift_r_nxt, ctrl_nxt, alt_nxt, caps_nxt;
    logic [3:0]      mods_nxt;
    logic            held_vld, held_vld_nxt;
    logic [8:0]      held_key, held_key_nxt;

    logic            vld_p0;
    key_event_t      ev_p0;
    key_event_t      head_ev;
    logic            fifo_empty;
    logic            fifo_full;
    logic            pop;
    logic            drop;

    assign timeout_hit = (state != IDLE) && !rx_valid &&
                         (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pause_cnt <= '0;
        end else begin
            state     <= state_nxt;
            pause_cnt <= pause_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        pause_nxt = pause_cnt;
        if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (rx_data == PFX_E0) begin
                        state_nxt = GOT_E0;
                    end else if (rx_data == BREAK_CODE) begin
                        state_nxt = GOT_F0;
                    end else if (rx_data == PFX_E1) begin
                        state_nxt = SKIP_E1;
                        pause_nxt = PAUSE_TAIL_LEN;
                    end
                end
                GOT_E0: begin
                    state_nxt = (rx_data == BREAK_CODE) ? GOT_E0F0 : IDLE;
                end
                GOT_F0, GOT_E0F0: begin
                    state_nxt = IDLE;
                end
                SKIP_E1: begin
                    pause_nxt = pause_cnt - 3'd1;
                    if (pause_cnt == 3'd1) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end else if (timeout_hit) begin
            state_nxt = IDLE;
            pause_nxt = '0;
        end
    end

    // FSM outputs: candidate event formed from the current byte
    always_comb begin
        form_vld   = 1'b0;
        form_code  = rx_data;
        form_ext   = 1'b0;
        form_brk   = 1'b0;
        form_pause = 1'b0;
        if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (rx_data != PFX_E0 && rx_data != BREAK_CODE &&
                        rx_data != PFX_E1 && !is_ignored(rx_data)) begin
                        form_vld = 1'b1;
                    end
                end
                GOT_E0: begin
                    if (rx_data != BREAK_CODE && rx_data != CODE_LSHIFT) begin
                        form_vld = 1'b1;
                        form_ext = 1'b1;
                    end
                end
                GOT_F0: begin
                    form_vld = 1'b1;
                    form_brk = 1'b1;
                end
                GOT_E0F0: begin
                    if (rx_data != CODE_LSHIFT) begin
                        form_vld = 1'b1;
                        form_ext = 1'b1;
                        form_brk = 1'b1;
                    end
                end
                SKIP_E1: begin
                    if (pause_cnt == 3'd1 && PAUSE_EN != 0) begin
                        form_vld   = 1'b1;
                        form_code  = CODE_PAUSE;
                        form_ext   = 1'b1;
                        form_pause = 1'b1;
                    end
                end
                default: begin
                    form_vld = 1'b0;
                end
            endcase
        end
    end

    // Idle timeout: only runs while a prefix sequence is open
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (rx_valid || state == IDLE || timeout_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    // Pause has no break code, so it never becomes (or matches) the held key
    assign is_repeat = form_vld && !form_brk && !form_pause && held_vld &&
                       (held_key == {form_ext, form_code});

    assign vld_p0 = form_vld && !(is_repeat && TYPEMATIC_EN == 0);

    always_comb begin
        shift_l_nxt  = shift_l;
        shift_r_nxt  = shift_r;
        ctrl_nxt     = ctrl_q;
        alt_nxt      = alt_q;
        caps_nxt     = caps_q;
        held_vld_nxt = held_vld;
        held_key_nxt = held_key;
        if (vld_p0 && !form_pause) begin
            case (form_code)
                CODE_LSHIFT: shift_l_nxt = !form_brk;
                CODE_RSHIFT: shift_r_nxt = !form_brk;
                CODE_CTRL:   ctrl_nxt    = !form_brk;
                CODE_ALT:    alt_nxt     = !form_brk;
                CODE_CAPS: begin
                    if (!form_brk && !is_repeat) begin
                        caps_nxt = !caps_q;
                    end
                end
                default: begin
                    caps_nxt = caps_q;
                end
            endcase
            if (!form_brk) begin
                held_vld_nxt = 1'b1;
                held_key_nxt = {form_ext, form_code};
            end else if (held_vld && held_key == {form_ext, form_code}) begin
                held_vld_nxt = 1'b0;
            end
        end
    end

    always_comb begin
        mods_nxt            = '0;
        mods_nxt[MOD_SHIFT] = shift_l_nxt | shift_r_nxt;
        mods_nxt[MOD_CTRL]  = ctrl_nxt;
        mods_nxt[MOD_ALT]   = alt_nxt;
        mods_nxt[MOD_CAPS]  = caps_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_l  <= 1'b0;
            shift_r  <= 1'b0;
            ctrl_q   <= 1'b0;
            alt_q    <= 1'b0;
            caps_q   <= 1'b0;
            held_vld <= 1'b0;
            held_key <= '0;
        end else begin
            shift_l  <= shift_l_nxt;
            shift_r  <= shift_r_nxt;
            ctrl_q   <= ctrl_nxt;
            alt_q    <= alt_nxt;
            caps_q   <= caps_nxt;
            held_vld <= held_vld_nxt;
            held_key <= held_key_nxt;
        end
    end

    always_comb begin
        ev_p0.code = form_code;
        ev_p0.ext  = form_ext;
        ev_p0.brk  = form_brk;
        ev_p0.mods = mods_nxt;
    end

    // Stage boundary: event written into the FIFO on the byte's own edge
    assign pop  = ev_valid & ev_ready;
    assign drop = vld_p0 & fifo_full & ~pop;

    ps2_key_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     ($bits(key_event_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (vld_p0),
        .wr_data (ev_p0),
        .rd_en   (pop),
        .rd_data (head_ev),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ov_clr) begin
            overflow <= 1'b0;
        end
    end

    assign ev_valid = ~fifo_empty;
    assign ev_code  = head_ev.code;
    assign ev_ext   = head_ev.ext;
    assign ev_break = head_ev.brk;
    assign ev_mods  = head_ev.mods;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder. Two instances share one byte stream:
//   dut0: FIFO_DEPTH=4, typematic suppressed, Pause decoded
//   dut1: FIFO_DEPTH=8, typematic reported, Pause discarded
// Expected events are queued per instance and compared as the FIFOs drain.
module tb_ps2_key_decoder;

    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       ov_clr;
    logic       ev_ready0, ev_ready1;

    logic       ev_valid0, ev_ext0, ev_break0, overflow0;
    logic [7:0] ev_code0;
    logic [3:0] ev_mods0;
    logic [2:0] fc0;

    logic       ev_valid1, ev_ext1, ev_break1, overflow1;
    logic [7:0] ev_code1;
    logic [3:0] ev_mods1;
    logic [3:0] fc1;

    logic [13:0] q0[$];
    logic [13:0] q1[$];

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    ps2_key_decoder #(
        .FIFO_DEPTH(4), .TYPEMATIC_EN(0), .TIMEOUT_CYC(TO), .PAUSE_EN(1)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .ev_valid(ev_valid0), .ev_ready(ev_ready0), .ev_code(ev_code0),
        .ev_ext(ev_ext0), .ev_break(ev_break0), .ev_mods(ev_mods0),
        .fifo_count(fc0), .overflow(overflow0), .ov_clr(ov_clr)
    );

    ps2_key_decoder #(
        .FIFO_DEPTH(8), .TYPEMATIC_EN(1), .TIMEOUT_CYC(TO), .PAUSE_EN(0)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .ev_valid(ev_valid1), .ev_ready(ev_ready1), .ev_code(ev_code1),
        .ev_ext(ev_ext1), .ev_break(ev_break1), .ev_mods(ev_mods1),
        .fifo_count(fc1), .overflow(overflow1), .ov_clr(ov_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] head(input int d);
        if (d == 0) return {ev_code0, ev_ext0, ev_break0, ev_mods0};
        return {ev_code1, ev_ext1, ev_break1, ev_mods1};
    endfunction

    function automatic logic valid(input int d);
        return (d == 0) ? ev_valid0 : ev_valid1;
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic exp_ev(input int d, input logic [7:0] code, input logic ext,
                          input logic brk, input logic [3:0] mods);
        if (d == 0) q0.push_back({code, ext, brk, mods});
        else        q1.push_back({code, ext, brk, mods});
    endtask

    task automatic exp_both(input logic [7:0] code, input logic ext,
                            input logic brk, input logic [3:0] mods);
        exp_ev(0, code, ext, brk, mods);
        exp_ev(1, code, ext, brk, mods);
    endtask

    task automatic pop_one(input int d);
        logic [13:0] exp;
        int n;
        if (d == 0) exp = q0.pop_front();
        else        exp = q1.pop_front();
        n = 0;
        while (!valid(d) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("dut%0d_ev_valid", d), {31'd0, valid(d)}, 32'd1);
        check($sformatf("dut%0d_event", d), {18'd0, head(d)}, {18'd0, exp});
        if (d == 0) ev_ready0 = 1'b1;
        else        ev_ready1 = 1'b1;
        @(negedge clk);
        ev_ready0 = 1'b0;
        ev_ready1 = 1'b0;
    endtask

    task automatic drain(input int d);
        while ((d == 0 ? q0.size() : q1.size()) > 0) pop_one(d);
        check($sformatf("dut%0d_count_drained", d),
              (d == 0) ? {29'd0, fc0} : {28'd0, fc1}, 32'd0);
    endtask

    task automatic drain_both();
        drain(0);
        drain(1);
    endtask

    initial begin
        logic [13:0] e;
        rst_n     = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        ov_clr    = 1'b0;
        ev_ready0 = 1'b0;
        ev_ready1 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_valid0", {31'd0, ev_valid0}, 32'd0);
        check("rst_count0", {29'd0, fc0}, 32'd0);
        check("rst_ovf0", {31'd0, overflow0}, 32'd0);
        check("rst_head0", {18'd0, head(0)}, 32'd0);
        check("rst_count1", {28'd0, fc1}, 32'd0);

        // Plain make/break, one-cycle latency
        send(8'h1C);
        check("latency_valid0", {31'd0, ev_valid0}, 32'd1);
        send(8'hF0); send(8'h1C);
        exp_both(8'h1C, 0, 0, 4'h0);
        exp_both(8'h1C, 0, 1, 4'h0);
        check("a_count0", {29'd0, fc0}, 32'd2);
        check("a_count1", {28'd0, fc1}, 32'd2);
        drain_both();

        // Shift held plus typematic repeat
        send(8'h12); send(8'h1C); send(8'h1C);
        send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        exp_ev(0, 8'h12, 0, 0, 4'h1);
        exp_ev(0, 8'h1C, 0, 0, 4'h1);
        exp_ev(0, 8'h1C, 0, 1, 4'h1);
        exp_ev(0, 8'h12, 0, 1, 4'h0);
        exp_ev(1, 8'h12, 0, 0, 4'h1);
        exp_ev(1, 8'h1C, 0, 0, 4'h1);
        exp_ev(1, 8'h1C, 0, 0, 4'h1);
        exp_ev(1, 8'h1C, 0, 1, 4'h1);
        exp_ev(1, 8'h12, 0, 1, 4'h0);
        check("b_count0", {29'd0, fc0}, 32'd4);
        check("b_count1", {28'd0, fc1}, 32'd5);
        check("b_ovf0", {31'd0, overflow0}, 32'd0);
        drain_both();

        // Extended keys and fake shift
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'h12); send(8'hE0); send(8'h7C);
        exp_both(8'h75, 1, 0, 4'h0);
        exp_both(8'h75, 1, 1, 4'h0);
        exp_both(8'h7C, 1, 0, 4'h0);
        drain_both();

        // Caps lock toggles on, then off
        send(8'h58); send(8'hF0); send(8'h58);
        send(8'h58); send(8'hF0); send(8'h58);
        exp_both(8'h58, 0, 0, 4'h8);
        exp_both(8'h58, 0, 1, 4'h8);
        exp_both(8'h58, 0, 0, 4'h0);
        exp_both(8'h58, 0, 1, 4'h0);
        drain_both();

        // Right ctrl and alt
        send(8'hE0); send(8'h14); send(8'hE0); send(8'hF0); send(8'h14);
        send(8'h11); send(8'hF0); send(8'h11);
        exp_both(8'h14, 1, 0, 4'h2);
        exp_both(8'h14, 1, 1, 4'h0);
        exp_both(8'h11, 0, 0, 4'h4);
        exp_both(8'h11, 0, 1, 4'h0);
        drain_both();

        // Pause sequence, then a normal key proves the FSM is back in IDLE
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        check("pause_count0", {29'd0, fc0}, 32'd1);
        check("pause_count1", {28'd0, fc1}, 32'd0);
        send(8'h1C); send(8'hF0); send(8'h1C);
        exp_ev(0, 8'h77, 1, 0, 4'h0);
        exp_both(8'h1C, 0, 0, 4'h0);
        exp_both(8'h1C, 0, 1, 4'h0);
        drain_both();

        // Overflow on the depth-4 instance
        send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
        exp_ev(0, 8'h1C, 0, 0, 4'h0);
        exp_ev(0, 8'h32, 0, 0, 4'h0);
        exp_ev(0, 8'h21, 0, 0, 4'h0);
        exp_ev(0, 8'h23, 0, 0, 4'h0);
        exp_ev(1, 8'h1C, 0, 0, 4'h0);
        exp_ev(1, 8'h32, 0, 0, 4'h0);
        exp_ev(1, 8'h21, 0, 0, 4'h0);
        exp_ev(1, 8'h23, 0, 0, 4'h0);
        exp_ev(1, 8'h24, 0, 0, 4'h0);
        check("ovf_count0", {29'd0, fc0}, 32'd4);
        check("ovf_flag0", {31'd0, overflow0}, 32'd1);
        check("ovf_flag1", {31'd0, overflow1}, 32'd0);
        check("ovf_count1", {28'd0, fc1}, 32'd5);

        // A drop in the same cycle as ov_clr keeps the flag set
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 8'h2C; ov_clr = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; ov_clr = 1'b0;
        exp_ev(1, 8'h2C, 0, 0, 4'h0);
        check("drop_wins_ovf0", {31'd0, overflow0}, 32'd1);
        check("drop_count0", {29'd0, fc0}, 32'd4);

        @(negedge clk);
        ov_clr = 1'b1;
        @(negedge clk);
        ov_clr = 1'b0;
        check("ov_clr0", {31'd0, overflow0}, 32'd0);

        // Push and pop together while full
        e = q0.pop_front();
        check("full_head0", {18'd0, head(0)}, {18'd0, e});
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 8'h2B; ev_ready0 = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; ev_ready0 = 1'b0;
        exp_both(8'h2B, 0, 0, 4'h0);
        check("pushpop_count0", {29'd0, fc0}, 32'd4);
        check("pushpop_ovf0", {31'd0, overflow0}, 32'd0);
        check("pushpop_count1", {28'd0, fc1}, 32'd7);
        drain_both();

        // Short gap keeps the F0 prefix; a long gap abandons it
        send(8'hF0);
        repeat (10) @(negedge clk);
        send(8'h1C);
        exp_both(8'h1C, 0, 1, 4'h0);
        send(8'hF0);
        repeat (TO + 5) @(negedge clk);
        send(8'h1C);
        exp_both(8'h1C, 0, 0, 4'h0);
        drain_both();

        // Reset mid-sequence clears prefix, FIFO and modifiers
        send(8'h32); send(8'h12); send(8'hE0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_valid0", {31'd0, ev_valid0}, 32'd0);
        check("midrst_count1", {28'd0, fc1}, 32'd0);
        rst_n = 1'b1;
        send(8'h75);
        exp_both(8'h75, 0, 0, 4'h0);
        drain_both();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
